// File: rtl/mavg_pkg.sv
// Shared sizing helpers for the streaming moving-average block.
// Sum width and rounding bias are derived here so every user sizes them identically.
package mavg_pkg;

  // Wide enough to hold N full-scale samples without wrapping.
  function automatic int sum_width(input int data_w, input int log2_n);
    return data_w + log2_n;
  endfunction

  function automatic int round_const(input int log2_n, input bit round_en);
    return round_en ? (1 << (log2_n - 1)) : 0;
  endfunction

endpackage

// File: rtl/mavg_delay_line.sv
// Circular sample history of DEPTH entries.
// The read port returns the old contents at wr_ptr, i.e. the sample about to be overwritten.
module mavg_delay_line #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_ptr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[wr_ptr];

endmodule

// File: rtl/mavg_stream.sv
// Streaming moving average over the last 2^LOG2_N accepted samples.
// A running sum is updated per accepted sample; the output is the shifted (optionally rounded) sum.
module mavg_stream
  import mavg_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int LOG2_N      = 2,
  parameter int SIGNED_MODE = 0,
  parameter int ROUND       = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_full
);

  localparam int N      = 1 << LOG2_N;
  localparam int SUM_W  = sum_width(DATA_W, LOG2_N);
  localparam int FILL_W = LOG2_N + 1;
  localparam logic [SUM_W-1:0]  RND      = SUM_W'(round_const(LOG2_N, ROUND != 0));
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(N);

  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [LOG2_N-1:0] ptr_q, ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              out_valid_q, out_valid_d;
  logic              out_full_q, out_full_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              accept;
  logic              full;
  logic [DATA_W-1:0] x_old_raw;
  logic [DATA_W-1:0] x_old_sel;
  logic              new_sign, old_sign;
  logic [SUM_W-1:0]  x_new_ext, x_old_ext;
  logic [SUM_W-1:0]  sum_next;
  logic [SUM_W-1:0]  avg_wide;
  logic [DATA_W-1:0] avg_data;

  assign accept = in_valid & ~clr;
  assign full   = (fill_q == FILL_MAX);

  mavg_delay_line #(
    .DATA_W (DATA_W),
    .DEPTH  (N)
  ) u_delay (
    .clk     (clk),
    .wr_en   (accept),
    .wr_ptr  (ptr_q),
    .wr_data (in_data),
    .rd_data (x_old_raw)
  );

  // During warm-up the slot being overwritten holds no real sample, so it contributes zero.
  assign x_old_sel = full ? x_old_raw : '0;
  assign new_sign  = (SIGNED_MODE != 0) & in_data[DATA_W-1];
  assign old_sign  = (SIGNED_MODE != 0) & x_old_sel[DATA_W-1];
  assign x_new_ext = {{LOG2_N{new_sign}}, in_data};
  assign x_old_ext = {{LOG2_N{old_sign}}, x_old_sel};

  // The true window sum and its biased form always fit SUM_W bits, so modular adds are exact.
  assign sum_next = sum_q + x_new_ext - x_old_ext;
  assign avg_wide = sum_next + RND;

  always_comb begin
    if (SIGNED_MODE != 0) begin
      avg_data = DATA_W'($signed(avg_wide) >>> LOG2_N);
    end else begin
      avg_data = DATA_W'(avg_wide >> LOG2_N);
    end
  end

  always_comb begin
    sum_d       = sum_q;
    ptr_d       = ptr_q;
    fill_d      = fill_q;
    out_data_d  = out_data_q;
    out_full_d  = out_full_q;
    out_valid_d = 1'b0;
    if (clr) begin
      sum_d      = '0;
      ptr_d      = '0;
      fill_d     = '0;
      out_full_d = 1'b0;
    end else if (in_valid) begin
      sum_d       = sum_next;
      ptr_d       = ptr_q + 1'b1;
      fill_d      = full ? fill_q : fill_q + 1'b1;
      out_data_d  = avg_data;
      out_valid_d = 1'b1;
      out_full_d  = (fill_d == FILL_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      ptr_q       <= '0;
      fill_q      <= '0;
      out_data_q  <= '0;
      out_full_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      ptr_q       <= ptr_d;
      fill_q      <= fill_d;
      out_data_q  <= out_data_d;
      out_full_q  <= out_full_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_full  = out_full_q;

endmodule

// File: tb/tb_mavg_stream.sv
// Bench for mavg_stream: four parameter variants share one stimulus stream and one
// window model (last four accepted samples, averaged with floor division).
module tb_mavg_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;

  logic        ov  [4];
  logic [15:0] od  [4];
  logic        ofl [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Variant m: SIGNED_MODE = m bit 0, ROUND = m bit 1.
  mavg_stream #(.DATA_W(16), .LOG2_N(2), .SIGNED_MODE(0), .ROUND(0)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[0]), .out_data(od[0]), .out_full(ofl[0]));
  mavg_stream #(.DATA_W(16), .LOG2_N(2), .SIGNED_MODE(1), .ROUND(0)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[1]), .out_data(od[1]), .out_full(ofl[1]));
  mavg_stream #(.DATA_W(16), .LOG2_N(2), .SIGNED_MODE(0), .ROUND(1)) u2 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[2]), .out_data(od[2]), .out_full(ofl[2]));
  mavg_stream #(.DATA_W(16), .LOG2_N(2), .SIGNED_MODE(1), .ROUND(1)) u3 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[3]), .out_data(od[3]), .out_full(ofl[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] hist [$];
  logic        exp_valid = 1'b0;
  logic        exp_full  = 1'b0;
  logic [15:0] exp_data [4] = '{default: 16'h0};

  function automatic longint floor_div4(input longint a);
    longint q;
    q = a / 4;
    if ((a % 4 != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [15:0] model_avg(input int m);
    longint s;
    longint q;
    s = 0;
    for (int i = 0; i < hist.size(); i++) begin
      if ((m & 1) != 0) s += longint'($signed(hist[i]));
      else              s += longint'(hist[i]);
    end
    if ((m & 2) != 0) s += 2;
    q = floor_div4(s);
    return q[15:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      exp_valid <= 1'b0;
      exp_full  <= 1'b0;
      for (int m = 0; m < 4; m++) exp_data[m] <= 16'h0;
    end else if (clr) begin
      hist.delete();
      exp_valid <= 1'b0;
      exp_full  <= 1'b0;
    end else if (in_valid) begin
      hist.push_back(in_data);
      if (hist.size() > 4) void'(hist.pop_front());
      for (int m = 0; m < 4; m++) exp_data[m] <= model_avg(m);
      exp_valid <= 1'b1;
      exp_full  <= (hist.size() == 4);
    end else begin
      exp_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      check($sformatf("cyc_valid_u%0d", m), 32'(ov[m]),  32'(exp_valid));
      check($sformatf("cyc_data_u%0d", m),  32'(od[m]),  32'(exp_data[m]));
      check($sformatf("cyc_full_u%0d", m),  32'(ofl[m]), 32'(exp_full));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [15:0] d, input logic c);
    in_valid = v;
    in_data  = d;
    clr      = c;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  logic [15:0] e29  [5] = '{16'd25, 16'd50, 16'd75, 16'd100, 16'd100};
  logic [15:0] s31  [5] = '{16'd2, 16'd0, 16'd0, 16'd0, 16'd0};
  logic [15:0] e31r [5] = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd0};
  logic [15:0] s32  [5] = '{16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFD};
  logic [15:0] e32  [5] = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFC};

  initial begin
    logic [15:0] d;
    int r;
    @(negedge clk);
    check("reset_valid", 32'(ov[0]), 0);
    check("reset_data", 32'(od[0]), 0);
    check("reset_full", 32'(ofl[0]), 0);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'd100, 1'b0);
      check($sformatf("avg100_data%0d", i), 32'(od[0]), 32'(e29[i]));
      check($sformatf("avg100_full%0d", i), 32'(ofl[0]), (i >= 3) ? 1 : 0);
    end

    step(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'hFFFF, 1'b0);
      if (i >= 3) check($sformatf("maxval_data%0d", i), 32'(od[0]), 32'hFFFF);
    end

    step(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h8000, 1'b0);
    check("minneg_signed", 32'(od[1]), 32'h8000);

    step(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, s31[i], 1'b0);
      check($sformatf("round_data%0d", i), 32'(od[2]), 32'(e31r[i]));
      check($sformatf("trunc_data%0d", i), 32'(od[0]), 0);
    end

    step(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, s32[i], 1'b0);
      check($sformatf("signed_floor%0d", i), 32'(od[1]), 32'(e32[i]));
    end

    step(1'b0, 16'h0, 1'b1);
    step(1'b1, 16'd40, 1'b0);
    check("gap_first", 32'(od[0]), 32'd10);
    step(1'b0, 16'd7, 1'b0);
    check("gap_nopulse", 32'(ov[0]), 0);
    check("gap_hold", 32'(od[0]), 32'd10);
    step(1'b0, 16'd9, 1'b0);
    step(1'b1, 16'd40, 1'b0);
    check("gap_second", 32'(od[0]), 32'd20);
    step(1'b1, 16'd55, 1'b1);
    check("clr_nopulse", 32'(ov[0]), 0);
    check("clr_notfull", 32'(ofl[0]), 0);
    check("clr_holddata", 32'(od[0]), 32'd20);
    step(1'b1, 16'd8, 1'b0);
    check("clr_next", 32'(od[0]), 32'd2);

    step(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 16'd100, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(ov[0]), 0);
    check("midrst_data", 32'(od[0]), 0);
    check("midrst_full", 32'(ofl[0]), 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 16'd100, 1'b0);
    check("postrst_data", 32'(od[0]), 32'd25);
    check("postrst_full", 32'(ofl[0]), 0);

    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 199));
      case ($urandom_range(0, 4))
        0:       d = 16'hFFFF;
        1:       d = 16'h8000;
        2:       d = 16'h7FFF;
        3:       d = 16'h0000;
        default: d = 16'($urandom);
      endcase
      if (r == 0) begin
        in_valid = 1'b1;
        in_data  = d;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
      end else begin
        step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, d, (r < 6) ? 1'b1 : 1'b0);
      end
    end

    step(1'b0, 16'h0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mavg_stream.md
MAVG_STREAM -- requirements
Module: mavg_stream

Interface
REQ-001 Parameter DATA_W, default 16: sample width in bits, valid range 2..32.
REQ-002 Parameter LOG2_N, default 2: window length N = 2^LOG2_N, valid range 1..8.
REQ-003 Parameter SIGNED_MODE, default 0: 1 selects two's-complement samples and arithmetic shift.
REQ-004 Parameter ROUND, default 0: 1 selects round-half-up, 0 selects truncation (floor).
REQ-005 clk  in  1  clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 clr  in  1  synchronous flush of the window.
REQ-008 in_valid  in  1  in_data is sampled this cycle.
REQ-009 in_data  in  DATA_W  input sample.
REQ-010 out_valid  out  1  one-cycle pulse; out_data is updated.
REQ-011 out_data  out  DATA_W  window average, held between pulses.
REQ-012 out_full  out  1  N samples have been accepted since the last reset or clr.

Function
REQ-013 The block SHALL keep a running sum of width DATA_W+LOG2_N: sum_next = sum + x_new - x_old.
REQ-014 x_old SHALL be the sample accepted N acceptances earlier when fill count = N, and 0 otherwise; missing samples during warm-up count as zero.
REQ-015 Sample history SHALL be a circular buffer of depth N, indexed by a LOG2_N-bit write pointer that wraps N-1 -> 0.
REQ-016 The fill counter SHALL saturate at N and SHALL increment once per accepted sample.
REQ-017 With in_valid=1 and clr=0, the following SHALL occur on the next edge: out_data = (sum_next + (ROUND ? 2^(LOG2_N-1) : 0)) >> LOG2_N (arithmetic shift when SIGNED_MODE=1), out_valid=1, pointer advances, fill count updates. Latency is 1 cycle.
REQ-018 With in_valid=0 the block SHALL hold sum, pointer, fill count and out_data, and SHALL drive out_valid=0.
REQ-019 Intermediate arithmetic SHALL NOT overflow. The rounded result SHALL fit in DATA_W bits for all inputs, without saturation logic.
REQ-020 out_full SHALL rise on the edge that accepts the N-th sample, coinciding with that sample's out_valid pulse.
REQ-021 clr=1 SHALL zero sum, pointer, fill count, out_full and out_valid on the next edge. out_data SHALL hold its value. Buffer contents need not be cleared.
REQ-022 clr and in_valid in the same cycle: clr has priority and the sample SHALL be discarded.
REQ-023 Back-to-back in_valid SHALL be accepted at one sample per cycle with no stall.

Reset
REQ-024 rst SHALL asynchronously force sum=0, pointer=0, fill=0, out_valid=0, out_data=0, out_full=0.
REQ-025 Reset mid-stream SHALL discard all history. The first sample after release behaves as the first sample after clr.
REQ-026 Buffer RAM SHALL NOT require reset.

Structure
REQ-027 The following SHALL live in package mavg_pkg: the sum-width function (DATA_W+LOG2_N) and the rounding-constant function.
REQ-028 The circular buffer SHALL be the sub-module mavg_delay_line: parameters DATA_W and DEPTH; ports wr_en, wr_ptr, wr_data and rd_data (read-before-write at wr_ptr). It SHALL be inferable as RAM.

Verification (DATA_W=16, LOG2_N=2 unless stated)
REQ-029 Unsigned, truncate: in_valid on every cycle with 100,100,100,100,100 -> out_data 25,50,75,100,100; out_full rises with the 4th pulse.
REQ-030 Max value: 0xFFFF x 5 -> the last two outputs are 0xFFFF, no wrap. SIGNED_MODE=1: 0x8000 x 4 -> 0x8000.
REQ-031 ROUND=1, unsigned: 2,0,0,0 -> 1,1,1,1; then 0 -> 0. ROUND=0, same stimulus -> 0,0,0,0,0.
REQ-032 SIGNED_MODE=1, truncate: -4,-4,-4,-4 -> -1,-2,-3,-4; then -3 -> -4 (floor of -15/4).
REQ-033 Gapped input (in_valid 1,0,0,1 with 40,x,x,40) -> two out_valid pulses, outputs 10 then 20, out_data held during the gap. clr together with in_valid=1 -> no pulse, out_full=0; next sample 8 -> 2.
REQ-034 Apply rst mid-stream after 6 samples of 100 -> all outputs 0 immediately. After release, sample 100 -> 25, out_full=0.
